tea_encipher: RTL and testbench

// - Multi-cycle TEA block encryptor: 64-bit plaintext (iV0,iV1), 128-bit key (iK0..iK3) -> 64-bit ciphertext.
// - Forward counterpart of the team's TEA decipher block (module cipher).
// - Output of this block fed to the decipher with the same key and ROUND_NUMBER=32 must return the plaintext.
// - Start/done handshake; inputs are captured at start, so the upstream source may change them while busy.

---
 rtl/tea_encipher.sv | 177 +++++++++++++++++
 tb/tb_tea_encipher.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tea_encipher.sv
// Multi-cycle TEA block encryptor: five clock cycles per Feistel round, start/done handshake.
// Inputs are captured on the accepting edge, so the source may change them while the block is busy.
module tea_encipher #(
    parameter int unsigned           WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0]  DELTA        = 32'h9e3779b9,
    parameter int unsigned           ROUND_NUMBER = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iStart,
    input  logic [WORD_SIZE-1:0] iV0,
    input  logic [WORD_SIZE-1:0] iV1,
    input  logic [WORD_SIZE-1:0] iK0,
    input  logic [WORD_SIZE-1:0] iK1,
    input  logic [WORD_SIZE-1:0] iK2,
    input  logic [WORD_SIZE-1:0] iK3,
    output logic [WORD_SIZE-1:0] oC0,
    output logic [WORD_SIZE-1:0] oC1,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam int unsigned          CountW    = $clog2(ROUND_NUMBER) + 1;
    localparam logic [CountW-1:0]    LastCount = CountW'(ROUND_NUMBER - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddDelta,
        StMixV0,
        StUpdV0,
        StMixV1,
        StUpdV1,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [WORD_SIZE-1:0] v0_q, v0_d;
    logic [WORD_SIZE-1:0] v1_q, v1_d;
    logic [WORD_SIZE-1:0] k0_q, k0_d;
    logic [WORD_SIZE-1:0] k1_q, k1_d;
    logic [WORD_SIZE-1:0] k2_q, k2_d;
    logic [WORD_SIZE-1:0] k3_q, k3_d;
    logic [WORD_SIZE-1:0] sum_q, sum_d;
    logic [WORD_SIZE-1:0] aux1_q, aux1_d;
    logic [WORD_SIZE-1:0] aux2_q, aux2_d;
    logic [WORD_SIZE-1:0] aux3_q, aux3_d;
    logic [CountW-1:0]    count_q, count_d;
    logic [WORD_SIZE-1:0] c0_q, c0_d;
    logic [WORD_SIZE-1:0] c1_q, c1_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WORD_SIZE-1:0] mix;
    logic [WORD_SIZE-1:0] v1_new;

    // Round function result, shared by both half-round update states.
    assign mix    = aux1_q ^ aux2_q ^ aux3_q;
    assign v1_new = v1_q + mix;

    always_comb begin
        state_d = state_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        k0_d    = k0_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        k3_d    = k3_q;
        sum_d   = sum_q;
        aux1_d  = aux1_q;
        aux2_d  = aux2_q;
        aux3_d  = aux3_q;
        count_d = count_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            StIdle, StDone: begin
                if (iStart) begin
                    v0_d    = iV0;
                    v1_d    = iV1;
                    k0_d    = iK0;
                    k1_d    = iK1;
                    k2_d    = iK2;
                    k3_d    = iK3;
                    sum_d   = '0;
                    count_d = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StAddDelta;
                end
            end
            StAddDelta: begin
                sum_d   = sum_q + DELTA;
                state_d = StMixV0;
            end
            StMixV0: begin
                aux1_d  = (v1_q << 4) + k0_q;
                aux2_d  = v1_q + sum_q;
                aux3_d  = (v1_q >> 5) + k1_q;
                state_d = StUpdV0;
            end
            StUpdV0: begin
                v0_d    = v0_q + mix;
                state_d = StMixV1;
            end
            StMixV1: begin
                aux1_d  = (v0_q << 4) + k2_q;
                aux2_d  = v0_q + sum_q;
                aux3_d  = (v0_q >> 5) + k3_q;
                state_d = StUpdV1;
            end
            StUpdV1: begin
                v1_d    = v1_new;
                count_d = count_q + 1'b1;
                if (count_q == LastCount) begin
                    c0_d    = v0_q;
                    c1_d    = v1_new;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end else begin
                    state_d = StAddDelta;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            v0_q    <= '0;
            v1_q    <= '0;
            k0_q    <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
            sum_q   <= '0;
            aux1_q  <= '0;
            aux2_q  <= '0;
            aux3_q  <= '0;
            count_q <= '0;
            c0_q    <= '0;
            c1_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            k3_q    <= k3_d;
            sum_q   <= sum_d;
            aux1_q  <= aux1_d;
            aux2_q  <= aux2_d;
            aux3_q  <= aux3_d;
            count_q <= count_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oC0   = c0_q;
    assign oC1   = c1_q;
    assign oBusy = busy_q;
    assign oDone = done_q;

endmodule

// File: tb/tb_tea_encipher.sv
// Directed bench for tea_encipher: reset, known vector, input isolation, abort,
// back-to-back jobs and a round trip through a reference TEA decipher.
module tb_tea_encipher;

    logic        clk;
    logic        rst_n;
    logic        iStart;
    logic [31:0] iV0, iV1, iK0, iK1, iK2, iK3;
    logic [31:0] oC0, oC1;
    logic        oBusy, oDone;

    int checks   = 0;
    int failures = 0;
    bit overlap_seen = 1'b0;
    bit nonzero_seen = 1'b0;

    tea_encipher dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .iStart (iStart),
        .iV0    (iV0),
        .iV1    (iV1),
        .iK0    (iK0),
        .iK1    (iK1),
        .iK2    (iK2),
        .iK3    (iK3),
        .oC0    (oC0),
        .oC1    (oC1),
        .oBusy  (oBusy),
        .oDone  (oDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (oBusy === 1'b1 && oDone === 1'b1) overlap_seen = 1'b1;
    end

    localparam logic [31:0] Delta = 32'h9e3779b9;

    function automatic logic [63:0] tea_enc(input logic [31:0] v0, v1,
                                            input logic [31:0] k0, k1, k2, k3);
        logic [31:0] sum = 32'h0;
        for (int r = 0; r < 32; r++) begin
            sum = sum + Delta;
            v0  = v0 + ((((v1 << 4) + k0)) ^ (v1 + sum) ^ ((v1 >> 5) + k1));
            v1  = v1 + ((((v0 << 4) + k2)) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
        end
        return {v0, v1};
    endfunction

    function automatic logic [63:0] tea_dec(input logic [31:0] v0, v1,
                                            input logic [31:0] k0, k1, k2, k3);
        logic [31:0] sum = 32'hc6ef3720;
        for (int r = 0; r < 32; r++) begin
            v1  = v1 - ((((v0 << 4) + k2)) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
            v0  = v0 - ((((v1 << 4) + k0)) ^ (v1 + sum) ^ ((v1 >> 5) + k1));
            sum = sum - Delta;
        end
        return {v0, v1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a vector and assert iStart for the accepting edge; returns #1 after that edge.
    task automatic do_start(input logic [31:0] v0, v1, k0, k1, k2, k3, input bit hold);
        @(negedge clk);
        iV0 = v0; iV1 = v1;
        iK0 = k0; iK1 = k1; iK2 = k2; iK3 = k3;
        iStart = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) iStart = 1'b0;
    endtask

    // Count edges until oDone; a timeout shows up as a wrong latency.
    task automatic wait_done(input bit scramble, input bit watch_zero, output int lat);
        lat = 0;
        while (lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
            if (oDone === 1'b1) break;
            if (watch_zero && (oC0 !== 32'h0 || oC1 !== 32'h0)) nonzero_seen = 1'b1;
            if (scramble) begin
                iV0 = $urandom; iV1 = $urandom;
                iK0 = $urandom; iK1 = $urandom; iK2 = $urandom; iK3 = $urandom;
                iStart = 1'($urandom_range(0, 1));
            end
        end
        if (scramble) iStart = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, {63'h0, oBusy}, 64'h0);
        chk({tag, "_done"}, {63'h0, oDone}, 64'h0);
        chk({tag, "_c0"},   {32'h0, oC0},   64'h0);
        chk({tag, "_c1"},   {32'h0, oC1},   64'h0);
    endtask

    initial begin
        int          lat;
        logic [63:0] exp_ct;
        logic [63:0] exp_ct2;
        logic [31:0] a0, a1, a2, a3, a4, a5;
        logic [31:0] b0, b1, b2, b3, b4, b5;

        rst_n  = 1'b0;
        iStart = 1'b0;
        iV0 = '0; iV1 = '0; iK0 = '0; iK1 = '0; iK2 = '0; iK3 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_all_zero("reset_idle");

        // Zero vector, known ciphertext.
        do_start(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("accept_busy", {63'h0, oBusy}, 64'h1);
        chk("accept_done", {63'h0, oDone}, 64'h0);
        wait_done(1'b0, 1'b0, lat);
        chk("zero_latency", 64'(lat), 64'd160);
        chk("zero_c0", {32'h0, oC0}, {32'h0, 32'h41ea3a0a});
        chk("zero_c1", {32'h0, oC1}, {32'h0, 32'h94baa940});
        chk("zero_busy_after", {63'h0, oBusy}, 64'h0);
        repeat (3) @(negedge clk);
        chk("done_hold", {63'h0, oDone}, 64'h1);
        chk("result_hold", {oC0, oC1}, 64'h41ea3a0a_94baa940);

        // Inputs scrambled and iStart pulsed while busy must not disturb the job.
        a0 = 32'h01234567; a1 = 32'h89abcdef;
        a2 = 32'h00112233; a3 = 32'h44556677; a4 = 32'h8899aabb; a5 = 32'hccddeeff;
        exp_ct = tea_enc(a0, a1, a2, a3, a4, a5);
        do_start(a0, a1, a2, a3, a4, a5, 1'b0);
        wait_done(1'b1, 1'b0, lat);
        chk("iso_latency", 64'(lat), 64'd160);
        chk("iso_result", {oC0, oC1}, exp_ct);

        // Asynchronous abort mid-job, then a clean restart.
        do_start(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        repeat (80) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("abort_idle");
        do_start(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        wait_done(1'b0, 1'b1, lat);
        chk("abort_no_partial", {63'h0, nonzero_seen}, 64'h0);
        chk("abort_latency", 64'(lat), 64'd160);
        chk("abort_result", {oC0, oC1}, 64'h41ea3a0a_94baa940);

        // Back-to-back with iStart held; second vector presented while the first runs.
        a0 = 32'hdeadbeef; a1 = 32'hcafef00d;
        a2 = 32'h0f1e2d3c; a3 = 32'h4b5a6978; a4 = 32'h8796a5b4; a5 = 32'hc3d2e1f0;
        b0 = 32'h13579bdf; b1 = 32'h2468ace0;
        b2 = 32'hffffffff; b3 = 32'h80000000; b4 = 32'h00000001; b5 = 32'h7fffffff;
        exp_ct  = tea_enc(a0, a1, a2, a3, a4, a5);
        exp_ct2 = tea_enc(b0, b1, b2, b3, b4, b5);
        do_start(a0, a1, a2, a3, a4, a5, 1'b1);
        iV0 = b0; iV1 = b1; iK0 = b2; iK1 = b3; iK2 = b4; iK3 = b5;
        wait_done(1'b0, 1'b0, lat);
        chk("b2b_first_latency", 64'(lat), 64'd160);
        chk("b2b_first_result", {oC0, oC1}, exp_ct);
        @(posedge clk);
        #1;
        iStart = 1'b0;
        chk("b2b_done_fall", {63'h0, oDone}, 64'h0);
        chk("b2b_busy_rise", {63'h0, oBusy}, 64'h1);
        wait_done(1'b0, 1'b0, lat);
        chk("b2b_second_latency", 64'(lat), 64'd160);
        chk("b2b_second_result", {oC0, oC1}, exp_ct2);

        // Round trip: ciphertext must decipher back to the plaintext.
        for (int n = 0; n < 100; n++) begin
            a0 = $urandom; a1 = $urandom;
            a2 = $urandom; a3 = $urandom; a4 = $urandom; a5 = $urandom;
            exp_ct = tea_enc(a0, a1, a2, a3, a4, a5);
            do_start(a0, a1, a2, a3, a4, a5, 1'b0);
            wait_done(1'b0, 1'b0, lat);
            chk($sformatf("rt_enc_%0d", n), {oC0, oC1}, exp_ct);
            chk($sformatf("rt_dec_%0d", n), tea_dec(oC0, oC1, a2, a3, a4, a5), {a0, a1});
        end

        chk("busy_done_overlap", {63'h0, overlap_seen}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
